// File: rtl/mem_request_ctrl.sv
// mem_request_ctrl
//   Data-memory request controller for the MIPS datapath. Turns a decoded
//   load/store into a registered request that is held until dhit, gates the
//   PC update on completion, and adds halt/flush handling, a watchdog that
//   parks the block in a sticky error state, and a saturating stall counter.
//
// Ports
//   CLK, nRST           clock, asynchronous active-low reset
//   ihit                instruction fetch complete this cycle
//   dhit                data access complete this cycle
//   dREN / dWEN         decoded load / store
//   daddr_in            ALU-computed data address
//   dstore_in           store data from the register file
//   halt                halt instruction decoded
//   flush               abort any outstanding request
//   dmemREN / dmemWEN   registered read / write request
//   dmemaddr            latched request address
//   dmemstore           latched store data
//   pcWEN               PC may advance this cycle (combinational)
//   busy                a request is outstanding
//   timeout_err         sticky watchdog error
//   stall_cnt           saturating count of request cycles without dhit
module mem_request_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr_in,
    input  logic [DATA_W-1:0] dstore_in,
    input  logic              halt,
    input  logic              flush,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              pcWEN,
    output logic              busy,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

    // The wait counter only has to reach TIMEOUT-2: the error is taken on
    // the edge where it would step to TIMEOUT-1, i.e. after TIMEOUT-1
    // stalled cycles.
    localparam int WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
    localparam logic [WAIT_W-1:0] TO_LAST_W = WAIT_W'(TO_LAST);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state, state_n;
    logic [WAIT_W-1:0] wait_cnt;

    logic mem_op;
    logic start;
    logic timeout_hit;
    logic ld_req;      // latch a new request this edge
    logic clr_req;     // drop the enables this edge
    logic stall;       // request cycle without completion
    logic set_err;

    assign mem_op      = dREN | dWEN;
    assign start       = ihit & mem_op & ~halt & ~flush;
    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt >= TO_LAST_W);
    assign busy        = (state == REQ);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        pcWEN   = 1'b0;
        ld_req  = 1'b0;
        clr_req = 1'b0;
        stall   = 1'b0;
        set_err = 1'b0;
        case (state)
            IDLE: begin
                // A data op defers the PC update to its dhit cycle.
                pcWEN = ihit & ~mem_op & ~halt;
                if (start) begin
                    ld_req  = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                // ihit is ignored here, so the REQ->IDLE edge can never
                // launch a back-to-back request.
                if (flush) begin
                    clr_req = 1'b1;
                    state_n = IDLE;
                end else if (dhit) begin
                    pcWEN   = 1'b1;
                    clr_req = 1'b1;
                    state_n = IDLE;
                end else begin
                    stall = 1'b1;
                    if (timeout_hit) begin
                        clr_req = 1'b1;
                        set_err = 1'b1;
                        state_n = ERR;
                    end
                end
            end
            ERR:     state_n = ERR;
            default: state_n = IDLE;
        endcase
    end

    // Request registers. Address and store data are only written on request
    // launch, so they stay put through REQ and afterwards.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
            dmemaddr  <= '0;
            dmemstore <= '0;
        end else if (ld_req) begin
            dmemaddr  <= daddr_in;
            dmemstore <= dstore_in;
            dmemWEN   <= dWEN;
            dmemREN   <= dREN & ~dWEN;   // write wins over read
        end else if (clr_req) begin
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt <= '0;
        end else if (ld_req) begin
            wait_cnt <= '0;
        end else if (stall) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)        timeout_err <= 1'b0;
        else if (set_err) timeout_err <= 1'b1;
    end

endmodule
